muldiv_unit: RTL

- Iterative RV32M multiply/divide unit. It is the multi-cycle counterpart to the single-cycle integer ALU in the execute stage.
- Execute issues an operation through a valid/ready start handshake.
- The unit computes one bit per cycle and returns the result through a valid/ready result handshake.
- Result is held until writeback accepts it.

---
 rtl/muldiv_unit.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Latency: accept in cycle 0, XLEN CALC cycles, result valid from cycle XLEN+1 (cycle 1 for special cases).
// Backpressure: result held in DONE until result_ready; start_ready low whenever not IDLE or killed.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start_valid,
  output logic            o_start_ready,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic            i_kill,
  output logic            o_result_valid,
  input  logic            i_result_ready,
  output logic [XLEN-1:0] o_result,
  output logic            o_busy
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [CW-1:0]     r_cnt;
  logic [2:0]        r_op;
  logic              r_neg_q;     // product / quotient must be negated at finish
  logic              r_neg_r;     // remainder takes the dividend's sign
  logic [XLEN-1:0]   r_opnd;      // multiplicand (mul) or divisor (div) magnitude
  logic [2*XLEN-1:0] r_acc;       // {partial product, multiplier} or {remainder, quotient}
  logic [XLEN-1:0]   r_result;

  logic              w_accept;
  logic              w_a_signed;
  logic              w_b_signed;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic              w_special;
  logic [XLEN-1:0]   w_special_res;

  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_step;
  logic [XLEN:0]     w_div_top;
  logic              w_div_ge;
  logic [XLEN-1:0]   w_div_diff;
  logic [XLEN-1:0]   w_div_rem;
  logic [2*XLEN-1:0] w_div_step;
  logic [2*XLEN-1:0] w_step;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quot_mag;
  logic [XLEN-1:0]   w_rem_mag;
  logic [XLEN-1:0]   w_quot;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_final;

  assign w_accept = (r_state == S_IDLE) && !i_kill && i_start_valid;

  // Only MULHU/DIVU/REMU (x11, 101, 111) treat a as unsigned; MULHSU additionally treats b as unsigned.
  assign w_a_signed = !(i_op[0] && (i_op[1] || i_op[2]));
  assign w_b_signed = w_a_signed && (i_op != 3'b010);
  assign w_a_neg    = w_a_signed && i_a[XLEN-1];
  assign w_b_neg    = w_b_signed && i_b[XLEN-1];
  assign w_a_mag    = w_a_neg ? (~i_a + 1'b1) : i_a;
  assign w_b_mag    = w_b_neg ? (~i_b + 1'b1) : i_b;

  // Divide-by-zero and signed overflow resolve at accept without iterating
  always_comb begin
    w_special     = 1'b0;
    w_special_res = '0;
    if (i_op[2]) begin
      if (i_b == '0) begin
        w_special     = 1'b1;
        w_special_res = i_op[1] ? i_a : '1;
      end else if (!i_op[0] && (i_a == {1'b1, {(XLEN-1){1'b0}}}) && (i_b == '1)) begin
        w_special     = 1'b1;
        w_special_res = i_op[1] ? '0 : i_a;
      end
    end
  end

  // Multiply step: conditionally add multiplicand to the upper half, then shift the whole pair right
  assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_step = {w_mul_sum, r_acc[XLEN-1:1]};

  // Divide step: shift remainder left taking the next dividend bit, subtract divisor if it fits
  assign w_div_top  = r_acc[2*XLEN-1:XLEN-1];
  assign w_div_ge   = w_div_top >= {1'b0, r_opnd};
  assign w_div_diff = w_div_top[XLEN-1:0] - r_opnd;
  assign w_div_rem  = w_div_ge ? w_div_diff : w_div_top[XLEN-1:0];
  assign w_div_step = {w_div_rem, r_acc[XLEN-2:0], w_div_ge};

  assign w_step = r_op[2] ? w_div_step : w_mul_step;

  // Sign fix-up and result selection applied to the final step's output
  assign w_prod     = r_neg_q ? (~w_step + 1'b1) : w_step;
  assign w_quot_mag = w_step[XLEN-1:0];
  assign w_rem_mag  = w_step[2*XLEN-1:XLEN];
  assign w_quot     = r_neg_q ? (~w_quot_mag + 1'b1) : w_quot_mag;
  assign w_rem      = r_neg_r ? (~w_rem_mag + 1'b1) : w_rem_mag;

  // Pick the result field for the latched opcode
  always_comb begin
    w_final = '0;
    case (r_op)
      3'b000:                 w_final = w_prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_final = w_prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_final = w_quot;
      default:                w_final = w_rem;
    endcase
  end

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next state and handshake outputs; kill beats a simultaneous result handshake
  always_comb begin
    w_next         = r_state;
    o_start_ready  = 1'b0;
    o_result_valid = 1'b0;
    o_busy         = 1'b1;
    case (r_state)
      S_IDLE: begin
        o_busy        = 1'b0;
        o_start_ready = !i_kill;
        if (w_accept) w_next = w_special ? S_DONE : S_CALC;
      end
      S_CALC: begin
        if (i_kill)              w_next = S_IDLE;
        else if (r_cnt == '0)    w_next = S_DONE;
      end
      S_DONE: begin
        o_result_valid = 1'b1;
        if (i_kill || i_result_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: latch operands on accept, iterate in CALC, register the result on the last step
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt    <= '0;
      r_op     <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_opnd   <= '0;
      r_acc    <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_cnt   <= CW'(XLEN-1);
      r_op    <= i_op;
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
      if (i_op[2]) begin
        r_opnd <= w_b_mag;
        r_acc  <= {{XLEN{1'b0}}, w_a_mag};
      end else begin
        r_opnd <= w_a_mag;
        r_acc  <= {{XLEN{1'b0}}, w_b_mag};
      end
      if (w_special) r_result <= w_special_res;
    end else if ((r_state == S_CALC) && !i_kill) begin
      r_acc <= w_step;
      r_cnt <= r_cnt - 1'b1;
      if (r_cnt == '0) r_result <= w_final;
    end
  end

  assign o_result = r_result;

endmodule
